width_128to24: RTL and testbench

//  Unpacks a stream of 128-bit words into a stream of 24-bit words. It is the inverse of the 24-to-128 packer.

---
 rtl/width_128to24.sv | 55 +++++
 tb/tb_width_128to24.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/width_128to24.sv
// Unpacks a stream of 128-bit words into 24-bit words, MSB-first, with no gaps between words.
// Valid/ready on both sides. The residue buffer is left-justified, and fill counts its valid bits.
module width_128to24 #(
   parameter int unsigned IN_W  = 128,
   parameter int unsigned OUT_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic [IN_W-1:0]  data_in,
   output logic             ready_in,
   output logic             valid_out,
   output logic [OUT_W-1:0] data_out,
   input  logic             ready_out
);

   localparam int unsigned BUF_W  = IN_W + OUT_W - 1;
   localparam int unsigned FILL_W = $clog2(BUF_W + 1);
   localparam int unsigned PAD_W  = OUT_W - 1;

   logic [BUF_W-1:0]  buf_q, buf_d, buf_p;
   logic [FILL_W-1:0] fill_q, fill_d, fill_p;
   logic              out_fire, in_fire;

   // Outputs come straight from the buffer registers and are forced idle during reset.
   assign valid_out = !rst && (fill_q >= FILL_W'(OUT_W));
   assign data_out  = rst ? '0 : buf_q[BUF_W-1 -: OUT_W];

   // Pop first, then place the new word directly below the bits that remain.
   always_comb begin
      out_fire = valid_out && ready_out;
      fill_p   = out_fire ? (fill_q - FILL_W'(OUT_W)) : fill_q;
      buf_p    = out_fire ? (buf_q << OUT_W) : buf_q;
      ready_in = !rst && (fill_p < FILL_W'(OUT_W));
      in_fire  = valid_in && ready_in;
      buf_d    = buf_p;
      fill_d   = fill_p;
      if (in_fire) begin
         // Bits below the valid region are always zero, so OR-ing in the shifted word is enough.
         buf_d  = buf_p | ({data_in, {PAD_W{1'b0}}} >> fill_p);
         fill_d = fill_p + FILL_W'(IN_W);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_q  <= '0;
         fill_q <= '0;
      end else begin
         buf_q  <= buf_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: tb/tb_width_128to24.sv
// Testbench for width_128to24. It checks the DUT against a bit-queue model of the serial stream.
module tb_width_128to24;

   logic         clk = 1'b0;
   logic         rst;
   logic         valid_in;
   logic [127:0] data_in;
   logic         ready_in;
   logic         valid_out;
   logic [23:0]  data_out;
   logic         ready_out;

   always #5 clk = ~clk;

   width_128to24 dut (
      .clk      (clk),
      .rst      (rst),
      .valid_in (valid_in),
      .data_in  (data_in),
      .ready_in (ready_in),
      .valid_out(valid_out),
      .data_out (data_out),
      .ready_out(ready_out)
   );

   int checks   = 0;
   int failures = 0;
   int acc_cnt  = 0;

   bit           bitq[$];
   logic [127:0] in_words[$];
   logic [23:0]  got[$];
   logic [23:0]  exp16[$];
   logic [23:0]  rnd48[$];

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] model_head();
      logic [23:0] w;
      for (int i = 0; i < 24; i++) w[23-i] = bitq[i];
      return w;
   endfunction

   // Packs groups of sixteen 24-bit words MSB-first into three 128-bit words.
   task automatic load_words(input logic [23:0] w[$]);
      logic [383:0] v;
      for (int g = 0; g < w.size() / 16; g++) begin
         for (int i = 0; i < 16; i++) v[383-24*i -: 24] = w[16*g+i];
         in_words.push_back(v[383:256]);
         in_words.push_back(v[255:128]);
         in_words.push_back(v[127:0]);
      end
   endtask

   task automatic check_got(input string tag, input logic [23:0] exp[$]);
      check_eq({tag, "_count"}, 128'(got.size()), 128'(exp.size()));
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         check_eq(tag, got[i], exp[i]);
   endtask

   // Entered and left just after a rising edge.
   task automatic do_reset();
      rst       = 1'b1;
      valid_in  = 1'b1;
      data_in   = '1;
      ready_out = 1'b1;
      @(negedge clk);
      check_eq("rst_valid_out", valid_out, 1'b0);
      check_eq("rst_ready_in", ready_in, 1'b0);
      check_eq("rst_data_out", data_out, 24'h0);
      @(posedge clk); #1;
      rst      = 1'b0;
      valid_in = 1'b0;
      data_in  = '0;
      bitq.delete();
      in_words.delete();
      got.delete();
   endtask

   task automatic run(input int max_cyc, input bit rnd_ready, input int stop_outs);
      bit          hold_prev = 1'b0;
      logic [23:0] held = '0;
      int          cyc  = 0;
      int          outs = 0;
      bit          ofire, ifire;
      int          fp;
      acc_cnt = 0;
      forever begin
         if (in_words.size() == 0 && bitq.size() < 24) break;
         if (stop_outs > 0 && outs >= stop_outs) break;
         if (cyc >= max_cyc) begin
            checks++;
            failures++;
            $display("FAIL timeout: got=%0d cycles exp=<%0d", cyc, max_cyc);
            break;
         end
         valid_in  = (in_words.size() > 0);
         data_in   = valid_in ? in_words[0] : '0;
         ready_out = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         check_eq("valid_out", valid_out, bitq.size() >= 24);
         if (hold_prev) begin
            check_eq("hold_data", data_out, held);
            check_eq("hold_valid", valid_out, 1'b1);
         end
         ofire = valid_out && ready_out;
         fp    = bitq.size() - ((ofire && bitq.size() >= 24) ? 24 : 0);
         check_eq("ready_in", ready_in, fp < 24);
         ifire = valid_in && ready_in;
         if (ofire && bitq.size() >= 24) begin
            check_eq("data_out", data_out, model_head());
            got.push_back(data_out);
            repeat (24) void'(bitq.pop_front());
            outs++;
         end
         hold_prev = valid_out && !ready_out;
         held      = data_out;
         if (ifire) begin
            for (int i = 127; i >= 0; i--) bitq.push_back(in_words[0][i]);
            void'(in_words.pop_front());
            if (cyc >= 16 && cyc < 80) acc_cnt++;
         end
         cyc++;
         @(posedge clk); #1;
      end
      valid_in  = 1'b0;
      ready_out = 1'b1;
   endtask

   initial begin
      logic [23:0] s2_exp[$];
      rst       = 1'b1;
      valid_in  = 1'b0;
      data_in   = '0;
      ready_out = 1'b1;
      for (int i = 0; i < 16; i++) exp16.push_back(24'(i));
      for (int i = 0; i < 48; i++) rnd48.push_back(24'($urandom));
      do_reset();

      // In-order sequence with no backpressure
      load_words(exp16);
      run(200, 1'b0, 0);
      check_got("s1", exp16);

      // Single word leaves an 8-bit residue that must prefix the next word
      do_reset();
      in_words.push_back(128'hABCDEF0123456789_FEDCBA9876543210);
      run(50, 1'b0, 0);
      s2_exp = '{24'hABCDEF, 24'h012345, 24'h6789FE, 24'hDCBA98, 24'h765432};
      check_got("s2", s2_exp);
      @(negedge clk);
      check_eq("s2_idle_valid", valid_out, 1'b0);
      check_eq("s2_idle_ready", ready_in, 1'b1);
      @(posedge clk); #1;
      in_words.push_back('1);
      run(50, 1'b0, 0);
      check_eq("s2_residue", (got.size() > 5) ? got[5] : 24'h0, 24'h10FFFF);

      // Random backpressure
      do_reset();
      load_words(exp16);
      run(600, 1'b1, 0);
      check_got("s3", exp16);

      // Steady stream: three accepts every sixteen cycles
      do_reset();
      for (int i = 0; i < 20; i++) in_words.push_back({$urandom, $urandom, $urandom, $urandom});
      run(400, 1'b0, 0);
      check_eq("s4_accept_rate", 128'(acc_cnt), 128'd12);
      check_eq("s4_out_count", 128'(got.size()), 128'd106);

      // Reset mid-stream, then a clean restart
      do_reset();
      load_words(exp16);
      run(200, 1'b0, 2);
      check_eq("s5_pre_count", 128'(got.size()), 128'd2);
      do_reset();
      load_words(exp16);
      run(200, 1'b0, 0);
      check_got("s5", exp16);

      // Random 24-bit words packed and unpacked again under backpressure
      do_reset();
      load_words(rnd48);
      run(800, 1'b1, 0);
      check_got("s6", rnd48);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
